// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a small write FIFO. Bytes queued through TX_DATA/TX_EN
//   are sent as 8N1-style frames: one start bit, 8 data bits LSB first, an
//   optional parity bit and 1 or 2 stop bits. The bit rate is derived from
//   sysclk by an internal divider of CLKS_PER_BIT cycles per bit.
//
// Ports
//   sysclk     in   system clock, all logic on posedge
//   reset      in   asynchronous active-low reset
//   TX_DATA    in   byte to queue
//   TX_EN      in   write strobe, one byte per cycle while high
//   TX_STATUS  out  1 = FIFO has space
//   TX_BUSY    out  1 = frame on the line or bytes still queued
//   TX_DROP    out  one-cycle pulse: the previous cycle's write was rejected
//   UART_TX    out  serial line, idles high, registered
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       TX_BUSY,
  output logic       TX_DROP,
  output logic       UART_TX
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          status_reg;
  logic          busy_reg;
  logic          drop_reg;

  // Transmit FSM
  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [2:0]    bit_idx_reg;
  logic          stop_idx_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic          tx_reg;

  logic [7:0] head;
  logic       head_parity;
  logic       bit_end;
  logic       stop_last;
  logic       frame_end;
  logic       pop;
  logic       push;
  logic       busy_next;

  assign head        = fifo_mem[rd_ptr_reg];
  assign head_parity = (PARITY == 2) ? ^head : ~^head;
  assign bit_end     = (timer_reg == BIT_LAST);
  assign stop_last   = (STOP_BITS == 1) ? 1'b1 : stop_idx_reg;
  assign frame_end   = (state_reg == STOP) && bit_end && stop_last;

  // The FSM takes a byte either from IDLE or straight out of the last stop
  // cycle, so consecutive frames carry no idle gap.
  assign pop  = (count_reg != '0) && ((state_reg == IDLE) || frame_end);

  // A full FIFO still accepts a write on the edge where the head is popped.
  assign push = TX_EN && ((count_reg != FIFO_FULL) || pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Busy is registered from post-edge values so it lines up with the
  // registered FSM state and FIFO count.
  always_comb begin
    busy_next = (count_next != '0);
    if (pop || ((state_reg != IDLE) && !frame_end)) begin
      busy_next = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= TX_DATA;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      status_reg <= 1'b1;
      busy_reg   <= 1'b0;
      drop_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg  <= count_next;
      status_reg <= (count_next != FIFO_FULL);
      busy_reg   <= busy_next;
      drop_reg   <= TX_EN && !push;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          timer_reg <= '0;
          tx_reg    <= 1'b1;
          if (pop) begin
            shift_reg  <= head;
            parity_reg <= head_parity;
            state_reg  <= START;
            tx_reg     <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        DATA: begin
          if (bit_end) begin
            timer_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              if (PARITY != 0) begin
                state_reg <= PAR;
                tx_reg    <= parity_reg;
              end else begin
                state_reg    <= STOP;
                stop_idx_reg <= 1'b0;
                tx_reg       <= 1'b1;
              end
            end else begin
              // The line shows shift_reg[0]; the next bit is one place up.
              bit_idx_reg <= bit_idx_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        PAR: begin
          if (bit_end) begin
            timer_reg    <= '0;
            state_reg    <= STOP;
            stop_idx_reg <= 1'b0;
            tx_reg       <= 1'b1;
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        STOP: begin
          if (bit_end) begin
            timer_reg <= '0;
            if (stop_last) begin
              if (pop) begin
                shift_reg  <= head;
                parity_reg <= head_parity;
                state_reg  <= START;
                tx_reg     <= 1'b0;
              end else begin
                state_reg <= IDLE;
                tx_reg    <= 1'b1;
              end
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end else begin
            timer_reg <= timer_reg + TIMER_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
          timer_reg <= '0;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign TX_STATUS = status_reg;
  assign TX_BUSY   = busy_reg;
  assign TX_DROP   = drop_reg;
  assign UART_TX   = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Three instances share clock and reset:
//   dut0: no parity, 1 stop bit; dut1: even parity, 2 stop bits;
//   dut2: odd parity, 1 stop bit. All use 16 clocks per bit, 4-entry FIFO.
// A frame-level reference model tracks queued bytes and frame start times;
// the expected line level is computed from the offset into the frame.
module tb_uart_tx_fifo;

  localparam int C     = 16;
  localparam int DEPTH = 4;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [2:0] en;
  logic [7:0] data [3];
  logic [2:0] line;
  logic [2:0] status;
  logic [2:0] busy;
  logic [2:0] drop;

  int tests  = 0;
  int failed = 0;

  int par_cfg  [3] = '{0, 2, 1};
  int stop_cfg [3] = '{1, 2, 1};

  always #5 sysclk = ~sysclk;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(data[0]), .TX_EN(en[0]),
    .TX_STATUS(status[0]), .TX_BUSY(busy[0]), .TX_DROP(drop[0]), .UART_TX(line[0])
  );
  uart_tx_fifo #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(data[1]), .TX_EN(en[1]),
    .TX_STATUS(status[1]), .TX_BUSY(busy[1]), .TX_DROP(drop[1]), .UART_TX(line[1])
  );
  uart_tx_fifo #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut2 (
    .sysclk(sysclk), .reset(reset), .TX_DATA(data[2]), .TX_EN(en[2]),
    .TX_STATUS(status[2]), .TX_BUSY(busy[2]), .TX_DROP(drop[2]), .UART_TX(line[2])
  );

  // ---------------- reference model ----------------
  int         cyc = 0;
  logic [7:0] mbuf [3][8];
  int         mhead [3] = '{0, 0, 0};
  int         mcnt [3] = '{0, 0, 0};
  int         m_start [3] = '{0, 0, 0};
  logic       m_active [3] = '{1'b0, 1'b0, 1'b0};
  logic       m_drop [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] m_byte [3];

  function automatic int frame_len(int k);
    return C * (10 + ((par_cfg[k] != 0) ? 1 : 0) + stop_cfg[k] - 1);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mhead[k]    = 0;
      mcnt[k]     = 0;
      m_active[k] = 1'b0;
      m_drop[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    bit fend;
    bit pop;
    bit acc;
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      fend = m_active[k] && (cyc == m_start[k] + frame_len(k));
      pop  = (mcnt[k] != 0) && (!m_active[k] || fend);
      acc  = en[k] && ((mcnt[k] < DEPTH) || pop);
      if (fend) m_active[k] = 1'b0;
      if (pop) begin
        m_byte[k]   = mbuf[k][mhead[k]];
        mhead[k]    = (mhead[k] + 1) % 8;
        mcnt[k]     = mcnt[k] - 1;
        m_start[k]  = cyc;
        m_active[k] = 1'b1;
      end
      if (acc) begin
        mbuf[k][(mhead[k] + mcnt[k]) % 8] = data[k];
        mcnt[k] = mcnt[k] + 1;
      end
      m_drop[k] = en[k] && !acc;
    end
  endtask

  always @(posedge sysclk or negedge reset) begin
    if (!reset) model_clear();
    else        model_step();
  end

  function automatic logic exp_line(int k);
    int off;
    int b;
    if (!m_active[k]) return 1'b1;
    off = cyc - m_start[k];
    b   = off / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[k][b-1];
    if (b == 9 && par_cfg[k] != 0) return (par_cfg[k] == 2) ? ^m_byte[k] : ~^m_byte[k];
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_vec(int k);
    return {exp_line(k), (mcnt[k] != DEPTH), (m_active[k] || (mcnt[k] != 0)), m_drop[k]};
  endfunction

  function automatic logic [3:0] obs_vec(int k);
    return {line[k], status[k], busy[k], drop[k]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int lows;
    repeat (3) @(negedge sysclk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs_vec(k) !== 4'b1100) begin
        failed++;
        $display("FAIL reset_hold dut%0d: got %b, want 1100", k, obs_vec(k));
      end
    end
    #1 reset = 1'b1;
    repeat (5) begin
      @(negedge sysclk);
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
    end
    // asynchronous reset between clock edges while idle
    @(posedge sysclk);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs_vec(k) !== 4'b1100) begin
        failed++;
        $display("FAIL reset_idle dut%0d: got %b, want 1100", k, obs_vec(k));
      end
    end
    @(negedge sysclk);
    #1 reset = 1'b1;
    // start a frame of zeros, then reset while the line is low
    data[0] = 8'h00;
    en[0]   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      en[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
    end
    @(posedge sysclk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (obs_vec(0) !== 4'b1100) begin
      failed++;
      $display("FAIL reset_frame dut0: got %b, want 1100", obs_vec(0));
    end
    repeat (3) @(negedge sysclk);
    #1 reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge sysclk);
      if (line[0] !== 1'b1) lows++;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
    end
    tests++;
    if (lows !== 0) begin
      failed++;
      $display("FAIL no_residual: got %0d low cycles, want 0", lows);
    end
  endtask

  task automatic test_single();
    int k_low;
    int k_bf;
    int off;
    logic [7:0] dec;
    k_low = -1;
    k_bf  = -1;
    dec   = '0;
    data[0] = 8'h55;
    en[0]   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      en[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (k_low < 0 && line[0] === 1'b0) k_low = i;
      if (k_low >= 0 && k_bf < 0 && busy[0] === 1'b0) k_bf = i;
      if (k_low >= 0) begin
        off = i - k_low;
        if (off % C == C / 2 && off / C >= 1 && off / C <= 8) dec[off / C - 1] = line[0];
      end
    end
    tests++;
    if (k_low !== 1) begin
      failed++;
      $display("FAIL start_latency: got %0d, want 1", k_low);
    end
    tests++;
    if (k_bf - k_low !== 160) begin
      failed++;
      $display("FAIL busy_fall: got %0d, want 160", k_bf - k_low);
    end
    tests++;
    if (dec !== 8'h55) begin
      failed++;
      $display("FAIL data_55: got %h, want 55", dec);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    int f1;
    int off;
    logic prev;
    logic [7:0] dec0;
    logic [7:0] dec1;
    f0 = -1;
    f1 = -1;
    prev = 1'b1;
    dec0 = '0;
    dec1 = '0;
    data[0] = 8'hA3;
    en[0]   = 1'b1;
    for (int i = 0; i < 360; i++) begin
      @(negedge sysclk);
      if (i == 0) data[0] = 8'h0F;
      else        en[0]   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (prev === 1'b1 && line[0] === 1'b0) begin
        if (f0 < 0) f0 = i;
        else if (f1 < 0 && i > f0 + 9 * C) f1 = i;
      end
      prev = line[0];
      if (f0 >= 0) begin
        off = i - f0;
        if (off % C == C / 2 && off / C >= 1 && off / C <= 8) dec0[off / C - 1] = line[0];
      end
      if (f1 >= 0) begin
        off = i - f1;
        if (off % C == C / 2 && off / C >= 1 && off / C <= 8) dec1[off / C - 1] = line[0];
      end
    end
    tests++;
    if (f0 !== 1) begin
      failed++;
      $display("FAIL b2b_first_start: got %0d, want 1", f0);
    end
    tests++;
    if (f1 - f0 !== 160) begin
      failed++;
      $display("FAIL b2b_gap: got %0d, want 160", f1 - f0);
    end
    tests++;
    if (dec0 !== 8'hA3) begin
      failed++;
      $display("FAIL b2b_byte0: got %h, want a3", dec0);
    end
    tests++;
    if (dec1 !== 8'h0F) begin
      failed++;
      $display("FAIL b2b_byte1: got %h, want 0f", dec1);
    end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses  = 0;
    data[0] = 8'h01;
    en[0]   = 1'b1;
    for (int i = 0; i < 900; i++) begin
      @(negedge sysclk);
      if (i < 5) data[0] = 8'(i + 2);
      else       en[0]   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (drop[0] === 1'b1) pulses++;
      if (i == 4) begin
        tests++;
        if (status[0] !== 1'b0) begin
          failed++;
          $display("FAIL ovf_status_full: got %b, want 0", status[0]);
        end
      end
      if (i == 5) begin
        tests++;
        if (drop[0] !== 1'b1) begin
          failed++;
          $display("FAIL ovf_drop_pulse: got %b, want 1", drop[0]);
        end
      end
    end
    tests++;
    if (pulses !== 1) begin
      failed++;
      $display("FAIL ovf_drop_count: got %0d, want 1", pulses);
    end
  endtask

  task automatic test_push_pop();
    int off;
    int k_bf;
    logic [7:0] dec;
    dec  = '0;
    k_bf = -1;
    data[0] = 8'h11;
    en[0]   = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sysclk);
      if (i < 4) begin
        data[0] = 8'(8'h12 + i);
      end else if (i == 160) begin
        data[0] = 8'h66;
        en[0]   = 1'b1;
      end else begin
        en[0] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (i == 161) begin
        tests++;
        if (drop[0] !== 1'b0) begin
          failed++;
          $display("FAIL pp_nodrop: got %b, want 0", drop[0]);
        end
        tests++;
        if (status[0] !== 1'b0) begin
          failed++;
          $display("FAIL pp_still_full: got %b, want 0", status[0]);
        end
      end
      if (i >= 801) begin
        off = i - 801;
        if (off % C == C / 2 && off / C >= 1 && off / C <= 8) dec[off / C - 1] = line[0];
      end
      if (i > 1 && k_bf < 0 && busy[0] === 1'b0) k_bf = i;
    end
    tests++;
    if (dec !== 8'h66) begin
      failed++;
      $display("FAIL pp_last_byte: got %h, want 66", dec);
    end
    tests++;
    if (k_bf !== 961) begin
      failed++;
      $display("FAIL pp_six_frames: busy fell at %0d, want 961", k_bf);
    end
  endtask

  task automatic test_parity();
    int bf1;
    int bf2;
    bf1 = -1;
    bf2 = -1;
    data[1] = 8'h07;
    data[2] = 8'h07;
    en[1]   = 1'b1;
    en[2]   = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(negedge sysclk);
      en[1] = 1'b0;
      en[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failed++;
          $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (i == 1 + 9 * C + C / 2) begin
        tests++;
        if (line[1] !== 1'b1) begin
          failed++;
          $display("FAIL par_even: got %b, want 1", line[1]);
        end
        tests++;
        if (line[2] !== 1'b0) begin
          failed++;
          $display("FAIL par_odd: got %b, want 0", line[2]);
        end
      end
      if (i == 1 + 11 * C + C / 2) begin
        tests++;
        if (line[1] !== 1'b1) begin
          failed++;
          $display("FAIL stop2_second: got %b, want 1", line[1]);
        end
      end
      if (i >= 1 && bf1 < 0 && busy[1] === 1'b0) bf1 = i;
      if (i >= 1 && bf2 < 0 && busy[2] === 1'b0) bf2 = i;
    end
    tests++;
    if (bf1 - 1 !== 192) begin
      failed++;
      $display("FAIL frame_even_2stop: got %0d, want 192", bf1 - 1);
    end
    tests++;
    if (bf2 - 1 !== 176) begin
      failed++;
      $display("FAIL frame_odd_1stop: got %0d, want 176", bf2 - 1);
    end
  endtask

  task automatic test_random();
    int rate [3] = '{2, 8, 40};
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 1200; i++) begin
        for (int k = 0; k < 3; k++) begin
          en[k]   = (p < 3) && ($urandom_range(0, 99) < rate[p]);
          data[k] = 8'($urandom);
        end
        @(negedge sysclk);
        for (int k = 0; k < 3; k++) begin
          tests++;
          if (obs_vec(k) !== exp_vec(k)) begin
            failed++;
            $display("FAIL model_dut%0d t=%0t: got %b, want %b", k, $time, obs_vec(k), exp_vec(k));
          end
        end
      end
    end
    en = '0;
  endtask

  initial begin
    reset = 1'b0;
    en    = '0;
    for (int k = 0; k < 3; k++) data[k] = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
